avr_tx_scheduler: RTL

- Shares the single AVR serial transmit channel between NUM_REQ byte-stream requesters, using packet-granular round-robin arbitration.
- Transmission is gated by link_ready, which is driven by the CCLK-based AVR-ready detector, and by the AVR tx_block flow-control pin.
- Sits between the on-FPGA producers and the serial_tx byte transmitter, and paces the one-byte-at-a-time handshake of serial_tx.

---
 rtl/avr_tx_scheduler.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/avr_tx_scheduler.sv
// Packet-granular round-robin scheduler sharing the AVR serial transmit channel
// between NUM_REQ byte-stream requesters, pacing serial_tx one byte at a time.
module avr_tx_scheduler #(
    parameter int NUM_REQ    = 2,
    parameter int MAX_PKT    = 64,
    parameter int BLOCK_SYNC = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   link_ready,
    input  logic                   avr_tx_block,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_data,
    output logic                   new_tx_data,
    input  logic                   tx_busy,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   pkt_abort
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam logic [7:0]       MAX_CNT  = 8'(MAX_PKT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, SEND, GUARD, DRAIN} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] rr_reg, owner_reg, sel_idx;
    logic [IDX_W:0]   scan_idx;
    logic             sel_found;
    logic [7:0]       cnt_reg, tx_data_reg, owner_byte;
    logic             last_reg;
    logic             blk, send_ok, accept, pkt_done, cnt_full;

    generate
        if (BLOCK_SYNC != 0) begin : g_blk_sync
            logic [1:0] blk_sync_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    blk_sync_reg <= 2'b00;
                end else begin
                    blk_sync_reg <= {blk_sync_reg[0], avr_tx_block};
                end
            end
            assign blk = blk_sync_reg[1];
        end else begin : g_blk_direct
            assign blk = avr_tx_block;
        end
    endgenerate

    assign send_ok    = link_ready & ~blk & ~tx_busy;
    assign owner_byte = req_data[{owner_reg, 3'b000} +: 8];
    assign cnt_full   = (cnt_reg == MAX_CNT);

    // First valid requester scanning from rr_reg upward, wrapping at NUM_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = rr_reg;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_reg} + (IDX_W+1)'(k);
            if (scan_idx >= (IDX_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (IDX_W+1)'(NUM_REQ);
            end
            if (!sel_found && req_valid[scan_idx[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (sel_found) state_next = SEND;
            SEND:    if (accept) state_next = GUARD;
            GUARD:   state_next = DRAIN;
            DRAIN:   if (!tx_busy) state_next = pkt_done ? IDLE : SEND;
            default: state_next = IDLE;
        endcase
    end

    // Strobe, ready and the outgoing byte are combinational so serial_tx sees
    // the byte in the same cycle as its load strobe.
    always_comb begin
        accept    = 1'b0;
        pkt_done  = 1'b0;
        pkt_abort = 1'b0;
        if (state_reg == SEND) begin
            accept = send_ok & req_valid[owner_reg];
        end
        if (state_reg == DRAIN && !tx_busy) begin
            pkt_done  = last_reg | cnt_full;
            pkt_abort = ~last_reg & cnt_full;
        end
        new_tx_data = accept;
        tx_data     = accept ? owner_byte : tx_data_reg;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign grant[gi]     = (state_reg != IDLE) && (owner_reg == IDX_W'(gi));
            assign req_ready[gi] = accept && (owner_reg == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_reg      <= '0;
            owner_reg   <= '0;
            cnt_reg     <= '0;
            last_reg    <= 1'b0;
            tx_data_reg <= '0;
        end else begin
            if (state_reg == IDLE && sel_found) begin
                owner_reg <= sel_idx;
            end
            if (accept) begin
                tx_data_reg <= owner_byte;
                cnt_reg     <= cnt_reg + 8'd1;
                last_reg    <= req_last[owner_reg];
            end
            if (pkt_done) begin
                rr_reg  <= (owner_reg == LAST_IDX) ? '0 : owner_reg + IDX_W'(1);
                cnt_reg <= '0;
            end
        end
    end

endmodule
